upower_multicycle_ctrl: RTL and testbench

- Multicycle sequencer for the uPower core: owns PC and instruction register, fetches from instruction memory, classifies opcode, steps ALU/memory/writeback/branch phases.
- Sits between imem/dmem and the instruction field parser; the parser consumes `ir`, the ALU and register file consume the strobes.
- Halts in a trap state on unsupported opcodes.

---
 rtl/upower_multicycle_ctrl_pkg.sv | 50 +++++
 rtl/upower_multicycle_ctrl_opclass_decode.sv | 25 ++
 rtl/upower_multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_upower_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/upower_multicycle_ctrl_pkg.sv
// Shared types for the uPower multicycle sequencer: FSM states, opcode
// numbers, instruction classes and branch-target sign extension.
package upower_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BR_I    = 3'd3,
    CL_BR_B    = 3'd4,
    CL_ILLEGAL = 3'd5
  } opclass_e;

  localparam logic [5:0] OP_ADDI  = 6'd14;
  localparam logic [5:0] OP_ADDIS = 6'd15;
  localparam logic [5:0] OP_B     = 6'd18;
  localparam logic [5:0] OP_BC    = 6'd19;
  localparam logic [5:0] OP_ORI   = 6'd24;
  localparam logic [5:0] OP_XORI  = 6'd26;
  localparam logic [5:0] OP_ANDI  = 6'd28;
  localparam logic [5:0] OP_X     = 6'd31;
  localparam logic [5:0] OP_LWZ   = 6'd32;
  localparam logic [5:0] OP_LBZ   = 6'd34;
  localparam logic [5:0] OP_STW   = 6'd36;
  localparam logic [5:0] OP_STB   = 6'd38;
  localparam logic [5:0] OP_LHZ   = 6'd40;
  localparam logic [5:0] OP_LHA   = 6'd42;
  localparam logic [5:0] OP_STH   = 6'd44;
  localparam logic [5:0] OP_LD    = 6'd58;
  localparam logic [5:0] OP_STD   = 6'd62;

  // Sign-extends the low `width` bits of field to 32 bits.
  function automatic logic [31:0] sext_target(input logic [31:0] field,
                                              input int unsigned width);
    logic [4:0] sh;
    sh = 5'(32 - width);
    return $signed(field << sh) >>> sh;
  endfunction

endpackage

// File: rtl/upower_multicycle_ctrl_opclass_decode.sv
// Combinational primary-opcode to instruction-class mapping.
module upower_opclass_decode
  import upower_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [2:0] opclass_o
);

  opclass_e cls;

  always_comb begin
    cls = CL_ILLEGAL;
    unique case (opcode_i)
      OP_X, OP_ADDI, OP_ADDIS, OP_ORI, OP_XORI, OP_ANDI: cls = CL_ALU;
      OP_LWZ, OP_LBZ, OP_LHZ, OP_LHA, OP_LD:             cls = CL_LOAD;
      OP_STW, OP_STB, OP_STH, OP_STD:                    cls = CL_STORE;
      OP_B:                                              cls = CL_BR_I;
      OP_BC:                                             cls = CL_BR_B;
      default:                                           cls = CL_ILLEGAL;
    endcase
  end

  assign opclass_o = cls;

endmodule

// File: rtl/upower_multicycle_ctrl.sv
// Multicycle uPower sequencer: owns PC/IR, steps fetch, decode, execute,
// memory and writeback phases, and traps on unsupported opcodes.
module upower_multicycle_ctrl
  import upower_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [31:0]      ir,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic             branch_cond,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_valid,
  output logic             rf_we,
  output logic             lr_we,
  output logic [31:0]      lr_wdata,
  output logic [31:0]      pc,
  output logic [2:0]       state_o,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      ir_q;
  logic [31:0]      lr_wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             imem_req_q;
  logic             alu_start_q;
  logic             dmem_req_q;
  logic             dmem_we_q;
  logic             rf_we_q;
  logic             lr_we_q;
  logic             illegal_q;

  logic [2:0]       cls_raw;
  opclass_e         cls;
  logic             is_branch;
  logic             retire;
  logic [31:0]      pc_plus4;
  logic [31:0]      base;

  upower_opclass_decode u_decode (
    .opcode_i  (ir_q[31:26]),
    .opclass_o (cls_raw)
  );

  assign cls       = opclass_e'(cls_raw);
  assign is_branch = (cls == CL_BR_I) || (cls == CL_BR_B);
  assign pc_plus4  = pc_q + 32'd4;

  // AA selects an absolute target; BC falls through when its condition is false.
  always_comb begin
    base = ir_q[1] ? '0 : pc_q;
    pc_d = pc_plus4;
    if (cls == CL_BR_I) begin
      pc_d = base + sext_target({6'b0, ir_q[25:2], 2'b00}, 32'd26);
    end else if (cls == CL_BR_B && branch_cond) begin
      pc_d = base + sext_target({16'b0, ir_q[15:2], 2'b00}, 32'd16);
    end
  end

  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      ST_EXEC: retire = is_branch;
      ST_MEM:  retire = dmem_valid && (cls == CL_STORE);
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Strobes are registered on the edge that enters the state they belong to,
  // so each is high exactly for the cycle(s) spent in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      lr_wdata_q  <= '0;
      cnt_q       <= '0;
      imem_req_q  <= 1'b0;
      alu_start_q <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      lr_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      alu_start_q <= 1'b0;
      rf_we_q     <= 1'b0;
      lr_we_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            ir_q       <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          unique case (cls)
            CL_ALU, CL_LOAD, CL_STORE: begin
              state_q     <= ST_EXEC;
              alu_start_q <= 1'b1;
            end
            CL_BR_I, CL_BR_B: begin
              state_q    <= ST_EXEC;
              lr_we_q    <= ir_q[0];
              lr_wdata_q <= ir_q[0] ? pc_plus4 : lr_wdata_q;
            end
            default: begin
              state_q   <= ST_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        ST_EXEC: begin
          if (!is_branch && alu_done) begin
            if (cls == CL_ALU) begin
              state_q <= ST_WB;
              rf_we_q <= 1'b1;
            end else begin
              state_q    <= ST_MEM;
              dmem_req_q <= 1'b1;
              dmem_we_q  <= (cls == CL_STORE);
            end
          end
        end
        ST_MEM: begin
          if (dmem_valid) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (cls == CL_LOAD) begin
              state_q <= ST_WB;
              rf_we_q <= 1'b1;
            end
          end
        end
        ST_WB: begin
          state_q <= ST_WB;
        end
        default: begin
          state_q <= ST_TRAP;
        end
      endcase
      if (retire) begin
        pc_q       <= pc_d;
        cnt_q      <= cnt_q + CNT_W'(1);
        state_q    <= run ? ST_FETCH : ST_IDLE;
        imem_req_q <= run;
      end
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign ir          = ir_q;
  assign alu_start   = alu_start_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign rf_we       = rf_we_q;
  assign lr_we       = lr_we_q;
  assign lr_wdata    = lr_wdata_q;
  assign pc          = pc_q;
  assign state_o     = state_q;
  assign illegal     = illegal_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_upower_multicycle_ctrl.sv
// Directed bench for upower_multicycle_ctrl: walks a short program through
// every instruction class, a run-drop, a trap and asynchronous resets.
module tb_upower_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_req, imem_valid, alu_start, alu_done;
  logic        branch_cond, dmem_req, dmem_we, dmem_valid, rf_we, lr_we, illegal;
  logic [31:0] imem_addr, imem_rdata, ir, lr_wdata, pc, retired_cnt;
  logic [2:0]  state_o;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  upower_multicycle_ctrl #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .ir          (ir),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .branch_cond (branch_cond),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_valid  (dmem_valid),
    .rf_we       (rf_we),
    .lr_we       (lr_we),
    .lr_wdata    (lr_wdata),
    .pc          (pc),
    .state_o     (state_o),
    .illegal     (illegal),
    .retired_cnt (retired_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    alu_done = 1'b0; branch_cond = 1'b0; dmem_valid = 1'b0;
    tick(); tick();
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=0", ir); end
    total++; if (retired_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
    total++; if ({imem_req, alu_start, dmem_req, dmem_we, rf_we, lr_we, illegal} !== 7'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000000",
                      {imem_req, alu_start, dmem_req, dmem_we, rf_we, lr_we, illegal});
    end
    total++; if (lr_wdata !== 32'h0) begin bad++; $display("FAIL reset_lr_wdata got=%h exp=0", lr_wdata); end
  endtask

  // add at pc 0, all handshakes zero-wait: F D E WB.
  task automatic test_alu();
    logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    imem_rdata = 32'h7C221A14; imem_valid = 1'b1; alu_done = 1'b1; dmem_valid = 1'b1;
    run = 1'b1; rst_n = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL alu_fetch req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
    for (int c = 1; c <= 4; c++) begin
      total++; if (state_o !== exp_st[c-1]) begin bad++; $display("FAIL alu_state c%0d got=%0d exp=%0d", c, state_o, exp_st[c-1]); end
      total++; if (rf_we !== (c == 4)) begin bad++; $display("FAIL alu_rf_we c%0d got=%b exp=%b", c, rf_we, (c == 4)); end
      total++; if (alu_start !== (c == 3)) begin bad++; $display("FAIL alu_start c%0d got=%b exp=%b", c, alu_start, (c == 3)); end
      tick();
    end
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL alu_pc got=%h exp=4", pc); end
    total++; if (retired_cnt !== 32'd1) begin bad++; $display("FAIL alu_cnt got=%0d exp=1", retired_cnt); end
    total++; if (ir !== 32'h7C221A14) begin bad++; $display("FAIL alu_ir got=%h exp=7c221a14", ir); end
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL alu_next got=%0d exp=1", state_o); end
  endtask

  // stw at pc 4: F D E M, store retires from MEM.
  task automatic test_store();
    logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    imem_rdata = 32'h90410008;
    for (int c = 1; c <= 4; c++) begin
      total++; if (state_o !== exp_st[c-1]) begin bad++; $display("FAIL st_state c%0d got=%0d exp=%0d", c, state_o, exp_st[c-1]); end
      total++; if ({dmem_req, dmem_we} !== {(c == 4), (c == 4)}) begin
        bad++; $display("FAIL st_dmem c%0d got=%b%b exp=%b%b", c, dmem_req, dmem_we, (c == 4), (c == 4));
      end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL st_rf_we c%0d got=%b exp=0", c, rf_we); end
      tick();
    end
    total++; if (pc !== 32'h8) begin bad++; $display("FAIL st_pc got=%h exp=8", pc); end
    total++; if (retired_cnt !== 32'd2) begin bad++; $display("FAIL st_cnt got=%0d exp=2", retired_cnt); end
  endtask

  // lwz at pc 8 with dmem_valid arriving in the fourth MEM cycle.
  task automatic test_load();
    logic [2:0] exp_st [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
    int req_cycles = 0;
    imem_rdata = 32'h80410004; dmem_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (dmem_req === 1'b1) req_cycles++;
      total++; if (state_o !== exp_st[c-1]) begin bad++; $display("FAIL ld_state c%0d got=%0d exp=%0d", c, state_o, exp_st[c-1]); end
      total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL ld_we c%0d got=%b exp=0", c, dmem_we); end
      total++; if (rf_we !== (c == 8)) begin bad++; $display("FAIL ld_rf_we c%0d got=%b exp=%b", c, rf_we, (c == 8)); end
      if (c == 7) dmem_valid = 1'b1;
      tick();
    end
    total++; if (req_cycles != 4) begin bad++; $display("FAIL ld_req_cycles got=%0d exp=4", req_cycles); end
    total++; if (pc !== 32'hC) begin bad++; $display("FAIL ld_pc got=%h exp=c", pc); end
    total++; if (retired_cnt !== 32'd3) begin bad++; $display("FAIL ld_cnt got=%0d exp=3", retired_cnt); end
  endtask

  // add at pc 0xC; run drops in EXEC and alu_done is one cycle late.
  task automatic test_run_drop();
    logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd5};
    imem_rdata = 32'h7C221A14; alu_done = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      total++; if (state_o !== exp_st[c-1]) begin bad++; $display("FAIL rd_state c%0d got=%0d exp=%0d", c, state_o, exp_st[c-1]); end
      total++; if (alu_start !== (c == 3)) begin bad++; $display("FAIL rd_alu_start c%0d got=%b exp=%b", c, alu_start, (c == 3)); end
      total++; if (rf_we !== (c == 5)) begin bad++; $display("FAIL rd_rf_we c%0d got=%b exp=%b", c, rf_we, (c == 5)); end
      if (c == 3) run = 1'b0;
      if (c == 4) alu_done = 1'b1;
      tick();
    end
    total++; if (state_o !== 3'd0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL rd_idle state=%0d req=%b exp state=0 req=0", state_o, imem_req);
    end
    total++; if (pc !== 32'h10 || retired_cnt !== 32'd4) begin
      bad++; $display("FAIL rd_retire pc=%h cnt=%0d exp pc=10 cnt=4", pc, retired_cnt);
    end
    tick();
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rd_hold got=%0d exp=0", state_o); end
    run = 1'b1; alu_done = 1'b0;
    tick();
    total++; if (state_o !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      bad++; $display("FAIL rd_resume state=%0d req=%b addr=%h exp 1 1 10", state_o, imem_req, imem_addr);
    end
  endtask

  // Branch sequence from pc 0x10: b+8 LK, b+8, bc false, b-4, bc true, ba 0x40 LK.
  task automatic test_branches();
    logic [31:0] words  [6] = '{32'h48000009, 32'h48000008, 32'h4C000010,
                                32'h4BFFFFFC, 32'h4C000010, 32'h48000043};
    logic        conds  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        lks    [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] lrs    [6] = '{32'h14, 32'h0, 32'h0, 32'h0, 32'h0, 32'h34};
    logic [31:0] pcs    [6] = '{32'h18, 32'h20, 32'h24, 32'h20, 32'h30, 32'h40};
    logic [2:0]  exp_st [3] = '{3'd1, 3'd2, 3'd3};
    for (int v = 0; v < 6; v++) begin
      imem_rdata = words[v]; branch_cond = conds[v];
      for (int c = 1; c <= 3; c++) begin
        total++; if (state_o !== exp_st[c-1]) begin bad++; $display("FAIL br%0d_state c%0d got=%0d exp=%0d", v, c, state_o, exp_st[c-1]); end
        total++; if (alu_start !== 1'b0) begin bad++; $display("FAIL br%0d_alu_start c%0d got=%b exp=0", v, c, alu_start); end
        total++; if (lr_we !== (lks[v] && c == 3)) begin bad++; $display("FAIL br%0d_lr_we c%0d got=%b exp=%b", v, c, lr_we, (lks[v] && c == 3)); end
        if (lks[v] && c == 3) begin
          total++; if (lr_wdata !== lrs[v]) begin bad++; $display("FAIL br%0d_lr_wdata got=%h exp=%h", v, lr_wdata, lrs[v]); end
        end
        tick();
      end
      total++; if (pc !== pcs[v] || state_o !== 3'd1) begin
        bad++; $display("FAIL br%0d_retire pc=%h state=%0d exp pc=%h state=1", v, pc, state_o, pcs[v]);
      end
    end
    branch_cond = 1'b0;
    total++; if (retired_cnt !== 32'd10) begin bad++; $display("FAIL br_cnt got=%0d exp=10", retired_cnt); end
  endtask

  // Opcode 0 at pc 0x40 traps until reset.
  task automatic test_trap();
    imem_rdata = 32'h00000000; alu_done = 1'b1; dmem_valid = 1'b1;
    tick(); tick();
    total++; if (state_o !== 3'd6 || illegal !== 1'b1) begin
      bad++; $display("FAIL trap_entry state=%0d illegal=%b exp 6 1", state_o, illegal);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      total++; if (illegal !== 1'b1 || pc !== 32'h40 || state_o !== 3'd6 || imem_req !== 1'b0) begin
        bad++; $display("FAIL trap_hold c%0d illegal=%b pc=%h state=%0d req=%b exp 1 40 6 0",
                        c, illegal, pc, state_o, imem_req);
      end
    end
    rst_n = 1'b0;
    #1;
    total++; if (state_o !== 3'd0 || pc !== 32'h0 || illegal !== 1'b0 || retired_cnt !== 32'd0) begin
      bad++; $display("FAIL trap_reset state=%0d pc=%h illegal=%b cnt=%0d exp 0 0 0 0",
                      state_o, pc, illegal, retired_cnt);
    end
  endtask

  // Reset asserted between edges while FETCH waits for imem_valid.
  task automatic test_async_reset();
    tick();
    imem_valid = 1'b0; run = 1'b1; rst_n = 1'b1;
    tick();
    total++; if (state_o !== 3'd1 || imem_req !== 1'b1) begin
      bad++; $display("FAIL ar_fetch state=%0d req=%b exp 1 1", state_o, imem_req);
    end
    tick();
    total++; if (state_o !== 3'd1 || imem_req !== 1'b1) begin
      bad++; $display("FAIL ar_wait state=%0d req=%b exp 1 1", state_o, imem_req);
    end
    #3 rst_n = 1'b0;
    #1;
    total++; if (state_o !== 3'd0 || imem_req !== 1'b0 || ir !== 32'h0) begin
      bad++; $display("FAIL ar_clear state=%0d req=%b ir=%h exp 0 0 0", state_o, imem_req, ir);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_run_drop();
    test_branches();
    test_trap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
